// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, bus widths, the slave's
// write/read FSM state encodings and a byte-strobe to bit-mask helper.
package axi_lite_pkg;

  localparam int AXI_DATA_W = 32;
  localparam int AXI_STRB_W = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_EXEC = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_e;

  // Expand each strobe bit into a full byte lane of the data mask.
  function automatic logic [AXI_DATA_W-1:0] strb_to_mask(input logic [AXI_STRB_W-1:0] strb);
    logic [AXI_DATA_W-1:0] mask;
    mask = '0;
    for (int i = 0; i < AXI_STRB_W; i++) begin
      mask[8*i +: 8] = {8{strb[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/axi_lite_regfile.sv
// Register storage for the AXI4-Lite slave: NUM_REGS 32-bit registers with
// a byte-masked write port, a registered read port (optionally forced to
// zero for out-of-range reads) and a flat export of every register.
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           srst,
  input  logic                           wr_en_i,
  input  logic [IDX_W-1:0]               wr_idx_i,
  input  logic [AXI_DATA_W-1:0]          wr_data_i,
  input  logic [AXI_STRB_W-1:0]          wr_strb_i,
  input  logic                           rd_en_i,
  input  logic [IDX_W-1:0]               rd_idx_i,
  input  logic                           rd_zero_i,
  output logic [AXI_DATA_W-1:0]          rd_data_o,
  output logic [AXI_DATA_W*NUM_REGS-1:0] reg_q_o
);

  logic [AXI_DATA_W-1:0] regs_q [NUM_REGS];
  logic [AXI_DATA_W-1:0] rd_data_q;
  logic [AXI_DATA_W-1:0] wr_mask;

  assign wr_mask = strb_to_mask(wr_strb_i);

  // Register array: clear on reset, merge strobed bytes into the target word.
  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      regs_q[wr_idx_i] <= (regs_q[wr_idx_i] & ~wr_mask) | (wr_data_i & wr_mask);
    end
  end

  // Read port: samples pre-write contents, so a same-edge commit is not seen.
  always_ff @(posedge clk) begin
    if (srst) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= rd_zero_i ? '0 : regs_q[rd_idx_i];
    end
  end

  assign rd_data_o = rd_data_q;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_export
      assign reg_q_o[AXI_DATA_W*gi +: AXI_DATA_W] = regs_q[gi];
    end
  endgenerate

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave register file. Independent write (IDLE/EXEC/RESP) and
// read (IDLE/RESP) handshake FSMs in front of axi_lite_regfile.
// Build option: define AXI_LITE_SLV_SLVERR_EN to answer out-of-range
// accesses with SLVERR instead of OKAY.
module axi_lite_slave_regs
  import axi_lite_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 32
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [ADDR_W-1:0]              S_AXI_AWADDR,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [AXI_DATA_W-1:0]          S_AXI_WDATA,
  input  logic [AXI_STRB_W-1:0]          S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_W-1:0]              S_AXI_ARADDR,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [AXI_DATA_W-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [AXI_DATA_W*NUM_REGS-1:0] REG_Q
);

  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int WORD_W = ADDR_W - 2;

`ifdef AXI_LITE_SLV_SLVERR_EN
  localparam logic [1:0] OOR_RESP = RESP_SLVERR;
`else
  localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

  // Byte-offset bits never influence decode.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // ---------------- write path state ----------------
  wr_state_e             w_state_q, w_state_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [WORD_W-1:0]     awword_q, awword_d;
  logic [AXI_DATA_W-1:0] wdata_q, wdata_d;
  logic [AXI_STRB_W-1:0] wstrb_q, wstrb_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  aw_hs, w_hs, aw_oor, wr_en;

  // ---------------- read path state ----------------
  rd_state_e             r_state_q, r_state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  ar_hs, ar_oor, rd_en;
  logic [WORD_W-1:0]     arword;

  assign aw_hs  = S_AXI_AWVALID && awready_q;
  assign w_hs   = S_AXI_WVALID && wready_q;
  assign aw_oor = |(awword_q >> IDX_W);

  assign arword = S_AXI_ARADDR[ADDR_W-1:2];
  assign ar_hs  = S_AXI_ARVALID && arready_q;
  assign ar_oor = |(arword >> IDX_W);

  // Write FSM state and captured address/data registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_q <= W_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awword_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      awword_q  <= awword_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Write FSM next state: collect AW and W in any order, commit once, respond.
  always_comb begin
    w_state_d = w_state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    awword_d  = awword_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    wr_en     = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_done_d = 1'b1;
          awword_d  = S_AXI_AWADDR[ADDR_W-1:2];
        end
        if (w_hs) begin
          w_done_d = 1'b1;
          wdata_d  = S_AXI_WDATA;
          wstrb_d  = S_AXI_WSTRB;
        end
        if (aw_done_d && w_done_d) begin
          w_state_d = W_EXEC;
        end
      end
      W_EXEC: begin
        wr_en     = !aw_oor;
        bvalid_d  = 1'b1;
        bresp_d   = aw_oor ? OOR_RESP : RESP_OKAY;
        w_state_d = W_RESP;
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_d  = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    // Each READY is a registered look-ahead so it drops right after its own handshake.
    awready_d = (w_state_d == W_IDLE) && !aw_done_d;
    wready_d  = (w_state_d == W_IDLE) && !w_done_d;
  end

  // Read FSM state and response code register.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
    end
  end

  // Read FSM next state: accept an address, hold the response until RREADY.
  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rd_en     = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          rd_en     = 1'b1;
          rvalid_d  = 1'b1;
          rresp_d   = ar_oor ? OOR_RESP : RESP_OKAY;
          r_state_d = R_RESP;
        end
      end
      R_RESP: begin
        if (S_AXI_RREADY) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

  axi_lite_regfile #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_regfile (
    .clk       (ACLK),
    .srst      (ARESET),
    .wr_en_i   (wr_en),
    .wr_idx_i  (awword_q[IDX_W-1:0]),
    .wr_data_i (wdata_q),
    .wr_strb_i (wstrb_q),
    .rd_en_i   (rd_en),
    .rd_idx_i  (arword[IDX_W-1:0]),
    .rd_zero_i (ar_oor),
    .rd_data_o (S_AXI_RDATA),
    .reg_q_o   (REG_Q)
  );

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Self-checking bench for axi_lite_slave_regs: directed scenarios followed
// by random writes/reads compared against an array model of the registers.
module tb_axi_lite_slave_regs;

  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = 32;
  localparam int REG_W    = 32 * NUM_REGS;
  localparam int BUDGET   = 50;

`ifdef AXI_LITE_SLV_SLVERR_EN
  localparam logic [1:0] ERR_EXP = 2'b10;
`else
  localparam logic [1:0] ERR_EXP = 2'b00;
`endif

  logic              ACLK = 1'b0;
  logic              ARESET;
  logic [ADDR_W-1:0] S_AXI_AWADDR;
  logic              S_AXI_AWVALID;
  logic              S_AXI_AWREADY;
  logic [31:0]       S_AXI_WDATA;
  logic [3:0]        S_AXI_WSTRB;
  logic              S_AXI_WVALID;
  logic              S_AXI_WREADY;
  logic [1:0]        S_AXI_BRESP;
  logic              S_AXI_BVALID;
  logic              S_AXI_BREADY;
  logic [ADDR_W-1:0] S_AXI_ARADDR;
  logic              S_AXI_ARVALID;
  logic              S_AXI_ARREADY;
  logic [31:0]       S_AXI_RDATA;
  logic [1:0]        S_AXI_RRESP;
  logic              S_AXI_RVALID;
  logic              S_AXI_RREADY;
  logic [REG_W-1:0]  REG_Q;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_regs [NUM_REGS];

  always #5 ACLK = ~ACLK;

  axi_lite_slave_regs #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
    .S_AXI_RREADY(S_AXI_RREADY),
    .REG_Q(REG_Q)
  );

  function automatic logic [REG_W-1:0] model_flat();
    logic [REG_W-1:0] v;
    for (int i = 0; i < NUM_REGS; i++) v[32*i +: 32] = model_regs[i];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [REG_W-1:0] obs, input logic [REG_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: observed timeout expected handshake within %0d cycles", tag, BUDGET);
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Full write transaction; W offered w_gap cycles and AW aw_gap cycles after the start.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_gap, input int w_gap, input int bhold, input string tag);
    bit aw_done, w_done, aw_hs, w_hs, in_range;
    int cyc;
    logic [1:0]  exp_resp;
    logic [31:0] mask;
    int idx;
    aw_done = 0; w_done = 0; cyc = 0;
    idx = int'(addr >> 2);
    in_range = (addr >> 2) < NUM_REGS;
    exp_resp = in_range ? 2'b00 : ERR_EXP;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    while (!(aw_done && w_done)) begin
      if (cyc >= BUDGET) begin
        timeout_fail({tag, "_aw_w"});
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
        return;
      end
      if (!aw_done && cyc >= aw_gap) S_AXI_AWVALID = 1;
      if (!w_done && cyc >= w_gap) S_AXI_WVALID = 1;
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs  = S_AXI_WVALID && S_AXI_WREADY;
      tick();
      if (aw_hs) begin aw_done = 1; S_AXI_AWVALID = 0; end
      if (w_hs)  begin w_done = 1;  S_AXI_WVALID = 0; end
      if (w_done && !aw_done) chk({tag, "_wready_wait"}, REG_W'(S_AXI_WREADY), '0);
      cyc++;
    end
    chk({tag, "_bvalid_exec"}, REG_W'(S_AXI_BVALID), '0);
    if (in_range) begin
      mask = '0;
      for (int b = 0; b < 4; b++) if (strb[b]) mask[8*b +: 8] = 8'hFF;
      model_regs[idx] = (model_regs[idx] & ~mask) | (data & mask);
    end
    tick();
    chk({tag, "_bvalid"}, REG_W'(S_AXI_BVALID), REG_W'(1'b1));
    chk({tag, "_bresp"}, REG_W'(S_AXI_BRESP), REG_W'(exp_resp));
    chk({tag, "_reg_q"}, REG_Q, model_flat());
    for (int h = 0; h < bhold; h++) begin
      tick();
      chk({tag, "_bvalid_hold"}, REG_W'(S_AXI_BVALID), REG_W'(1'b1));
      chk({tag, "_bresp_hold"}, REG_W'(S_AXI_BRESP), REG_W'(exp_resp));
      chk({tag, "_ready_block"}, REG_W'({S_AXI_AWREADY, S_AXI_WREADY}), '0);
    end
    S_AXI_BREADY = 1;
    tick();
    S_AXI_BREADY = 0;
    chk({tag, "_bvalid_clr"}, REG_W'(S_AXI_BVALID), '0);
    chk({tag, "_ready_back"}, REG_W'({S_AXI_AWREADY, S_AXI_WREADY}), REG_W'(2'b11));
    $display("write %s addr=%08h data=%08h strb=%b resp=%b", tag, addr, data, strb, exp_resp);
  endtask

  // Full read transaction with RREADY held low for rhold cycles.
  task automatic axi_read(input logic [31:0] addr, input int rhold, input string tag);
    bit hs, in_range;
    int cyc;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    in_range = (addr >> 2) < NUM_REGS;
    exp_data = in_range ? model_regs[int'(addr >> 2)] : 32'h0;
    exp_resp = in_range ? 2'b00 : ERR_EXP;
    S_AXI_ARADDR = addr;
    S_AXI_ARVALID = 1;
    cyc = 0;
    hs = 0;
    while (!hs) begin
      if (cyc >= BUDGET) begin
        timeout_fail({tag, "_ar"});
        S_AXI_ARVALID = 0;
        return;
      end
      hs = S_AXI_ARREADY;
      tick();
      cyc++;
    end
    S_AXI_ARVALID = 0;
    chk({tag, "_rvalid"}, REG_W'(S_AXI_RVALID), REG_W'(1'b1));
    chk({tag, "_rdata"}, REG_W'(S_AXI_RDATA), REG_W'(exp_data));
    chk({tag, "_rresp"}, REG_W'(S_AXI_RRESP), REG_W'(exp_resp));
    chk({tag, "_arready_busy"}, REG_W'(S_AXI_ARREADY), '0);
    for (int h = 0; h < rhold; h++) begin
      tick();
      chk({tag, "_rdata_hold"}, REG_W'({S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA}),
          REG_W'({1'b1, exp_resp, exp_data}));
    end
    S_AXI_RREADY = 1;
    tick();
    S_AXI_RREADY = 0;
    chk({tag, "_rvalid_clr"}, REG_W'(S_AXI_RVALID), '0);
    chk({tag, "_arready_back"}, REG_W'(S_AXI_ARREADY), REG_W'(1'b1));
    $display("read  %s addr=%08h data=%08h resp=%b", tag, addr, exp_data, exp_resp);
  endtask

  initial begin
    logic [31:0] old3, addr, data;
    logic [REG_W-1:0] before_oor;
    int sel;

    ARESET = 1;
    S_AXI_AWADDR = '0; S_AXI_AWVALID = 0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 0;
    S_AXI_BREADY = 0; S_AXI_ARADDR = '0; S_AXI_ARVALID = 0; S_AXI_RREADY = 0;
    for (int i = 0; i < NUM_REGS; i++) model_regs[i] = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_readys", REG_W'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), '0);
    chk("rst_valids", REG_W'({S_AXI_BVALID, S_AXI_RVALID}), '0);
    chk("rst_resps", REG_W'({S_AXI_BRESP, S_AXI_RRESP}), '0);
    chk("rst_rdata", REG_W'(S_AXI_RDATA), '0);
    chk("rst_reg_q", REG_Q, '0);
    ARESET = 0;
    tick();
    chk("rel_readys", REG_W'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), REG_W'(3'b111));

    // AW and W in the same cycle
    axi_write(32'h4, 32'h12345678, 4'hF, 0, 0, 0, "same_cycle");
    chk("reg1_const", REG_W'(REG_Q[63:32]), REG_W'(32'h12345678));
    axi_read(32'h4, 0, "rd_reg1");

    // W three cycles ahead of AW, partial strobe
    axi_write(32'h8, 32'h11223344, 4'hF, 0, 0, 0, "reg2_init");
    axi_write(32'h8, 32'hAABBCCDD, 4'b0101, 3, 0, 0, "w_first");
    chk("reg2_const", REG_W'(REG_Q[95:64]), REG_W'(32'h11BB33DD));

    // Held-off write response
    axi_write(32'h10, 32'hCAFEF00D, 4'hF, 1, 2, 5, "bhold5");

    // Zero strobe in range
    axi_write(32'h14, 32'hFFFFFFFF, 4'h0, 0, 0, 0, "strb0");

    // Out-of-range write and read
    before_oor = REG_Q;
    axi_write(32'h20, 32'h5A5A5A5A, 4'hF, 0, 0, 0, "oor_wr");
    chk("oor_reg_q_same", REG_Q, before_oor);
    axi_read(32'h20, 2, "oor_rd");

    // Read sampled on the same edge a W_EXEC commit hits register 3
    old3 = $urandom;
    axi_write(32'hC, old3, 4'hF, 0, 0, 0, "reg3_old");
    S_AXI_AWADDR = 32'hC; S_AXI_WDATA = 32'hDEADBEEF; S_AXI_WSTRB = 4'hF;
    chk("race_ready_pre", REG_W'({S_AXI_AWREADY, S_AXI_WREADY}), REG_W'(2'b11));
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
    tick();
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    S_AXI_ARADDR = 32'hC; S_AXI_ARVALID = 1;
    chk("race_arready", REG_W'(S_AXI_ARREADY), REG_W'(1'b1));
    tick();
    S_AXI_ARVALID = 0;
    model_regs[3] = 32'hDEADBEEF;
    chk("race_rvalid", REG_W'(S_AXI_RVALID), REG_W'(1'b1));
    chk("race_rdata_old", REG_W'(S_AXI_RDATA), REG_W'(old3));
    chk("race_bvalid", REG_W'(S_AXI_BVALID), REG_W'(1'b1));
    chk("race_reg_q", REG_Q, model_flat());
    S_AXI_BREADY = 1; S_AXI_RREADY = 1;
    tick();
    S_AXI_BREADY = 0; S_AXI_RREADY = 0;
    $display("race  reg3 old=%08h new=deadbeef", old3);
    axi_read(32'hC, 0, "rd_reg3_new");

    // Reset while in W_EXEC
    S_AXI_AWADDR = 32'h0; S_AXI_WDATA = 32'hFFFFFFFF; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
    tick();
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    ARESET = 1;
    tick();
    for (int i = 0; i < NUM_REGS; i++) model_regs[i] = '0;
    chk("mrst_bvalid", REG_W'(S_AXI_BVALID), '0);
    chk("mrst_readys", REG_W'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), '0);
    chk("mrst_reg_q", REG_Q, '0);
    ARESET = 0;
    tick();
    chk("mrst_readys_back", REG_W'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), REG_W'(3'b111));
    chk("mrst_no_bvalid", REG_W'(S_AXI_BVALID), '0);
    tick();
    chk("mrst_no_bvalid2", REG_W'(S_AXI_BVALID), '0);
    chk("mrst_reg0", REG_W'(REG_Q[31:0]), '0);
    $display("reset mid-write discarded");

    // Random traffic
    for (int t = 0; t < 40; t++) begin
      addr = (32'($urandom_range(0, NUM_REGS + 1)) << 2) | 32'($urandom_range(0, 3));
      data = $urandom;
      sel  = int'($urandom_range(0, 2));
      if (sel == 0) begin
        axi_read(addr, int'($urandom_range(0, 3)), "rnd_rd");
      end else begin
        axi_write(addr, data, 4'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), "rnd_wr");
      end
    end
    for (int i = 0; i < NUM_REGS; i++) axi_read(32'(i * 4), 0, "final_rd");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_slave_regs.md
# axi_lite_slave_regs

AXI4-Lite slave register file that terminates the write/read transactions issued by the team's AXI4-Lite master. It holds NUM_REGS 32-bit registers with byte-strobe writes and independent write and read paths. All register contents are exported flat for fabric logic.

## Interface
- NUM_REGS, 8: number of 32-bit registers; power of two, 2..256.
- ADDR_W, 32: AXI address width.
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  reset, synchronous, active-high.
- S_AXI_AWADDR  in  ADDR_W  write address.
- S_AXI_AWVALID  in  1 / S_AXI_AWREADY  out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables; bit i covers data bits [8i+7:8i].
- S_AXI_WVALID  in  1 / S_AXI_WREADY  out  1  write-data handshake.
- S_AXI_BRESP  out  2 / S_AXI_BVALID  out  1 / S_AXI_BREADY  in  1  write response.
- S_AXI_ARADDR  in  ADDR_W / S_AXI_ARVALID  in  1 / S_AXI_ARREADY  out  1  read address.
- S_AXI_RDATA  out  32 / S_AXI_RRESP  out  2 / S_AXI_RVALID  out  1 / S_AXI_RREADY  in  1  read data.
- REG_Q  out  32*NUM_REGS  register contents; register n at bits [32n+31:32n].

## Operation
- Decode: word index = ADDR[IDX_W+1:2], IDX_W = log2(NUM_REGS); ADDR[1:0] ignored; address >= 4*NUM_REGS is out of range.
- Write FSM W_IDLE -> W_EXEC -> W_RESP -> W_IDLE.
  - W_IDLE: AWREADY=1 until address captured, WREADY=1 until data captured; AW and W accepted in either order or same cycle; each READY drops the cycle after its own handshake.
  - Both captured -> W_EXEC (one cycle): in-range write applies WSTRB-masked data; out-of-range write dropped.
  - W_RESP: BVALID=1, BRESP valid, held stable until BREADY; on B handshake -> W_IDLE, AWREADY/WREADY re-asserted next cycle.
- Read FSM R_IDLE -> R_RESP -> R_IDLE.
  - R_IDLE: ARREADY=1. On AR handshake, RDATA/RRESP registered from current contents, RVALID=1, ARREADY=0.
  - R_RESP: RDATA/RRESP/RVALID held until RREADY; on R handshake -> R_IDLE.
- Read and write paths fully independent; read sampled at the same edge as a W_EXEC commit to the same register returns the old value.
- Out-of-range read: RDATA=0.
- WSTRB=0 in range: no change, BRESP=OKAY.

## Timing
- Reset values: AWREADY, WREADY, ARREADY, BVALID, RVALID = 0; BRESP, RRESP = 00; RDATA = 0; all registers and REG_Q = 0.
- First cycle after ARESET deasserts: AWREADY, WREADY, ARREADY = 1.
- Write latency: last of AW/W handshakes at edge k -> register updated and REG_Q visible after edge k+1, BVALID=1 after edge k+1.
- Read latency: AR handshake at edge k -> RVALID=1 after edge k.
- Back-to-back: one write per 3 cycles minimum, one read per 2 cycles minimum.
- ARESET mid-transaction: at that edge all state returns to reset values, captured address/data discarded, no response issued.

## Configuration
- AXI_LITE_SLV_SLVERR_EN defined: out-of-range write or read returns RESP=2'b10 (SLVERR).
- Undefined: out-of-range returns OKAY (2'b00); write still dropped and RDATA still 0.
- In-range accesses always return OKAY.

## Structure
- Shared package axi_lite_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, AXI_DATA_W=32, AXI_STRB_W=4, and the write/read FSM state enums.
- One sub-module, axi_lite_regfile: register array, strobe-masked write port, registered read port, REG_Q export.
- Handshake FSMs stay in the top.

## Test plan
- AW and W same cycle, addr 0x4, data 0x12345678, strobe 1111 -> BVALID two edges later with BRESP=00; REG_Q[63:32]=0x12345678; read 0x4 returns 0x12345678 with RRESP=00.
- W three cycles before AW, addr 0x8, data 0xAABBCCDD, strobe 0101 over prior 0x11223344 -> register 2 = 0x11BB33DD; WREADY low while waiting for AW.
- BREADY held low 5 cycles -> BVALID and BRESP stable; no new AW/W accepted until the B handshake.
- Write and read to addr 0x20 with NUM_REGS=8 -> with macro, BRESP=RRESP=10 and RDATA=0; without macro, both responses 00; REG_Q unchanged in both builds.
- ARESET pulsed while in W_EXEC after capture of addr 0x0 and data 0xFFFFFFFF -> no BVALID, register 0 = 0, READY signals return 1 one cycle after release.
- Read of register 3 at the same edge as W_EXEC writes 0xDEADBEEF to it -> RDATA = old value; next read returns 0xDEADBEEF.
